// File: rtl/prefetch_unit.sv
// prefetch_unit: fetches 16-bit code words at CS:IP and streams them,
// one byte per cycle, into the instruction byte FIFO. A redirect
// (load_new_ip) flushes the FIFO and restarts fetch at new_ip.
// Optional feature macro: PREFETCH_STALL_EN adds a 'stall' input that
// holds off new memory accesses without blocking pushes.
module prefetch_unit #(
    parameter logic [15:0] RESET_IP = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cs,
    input  logic [15:0] new_ip,
    input  logic        load_new_ip,
`ifdef PREFETCH_STALL_EN
    input  logic        stall,
`endif
    output logic        fifo_wr_en,
    output logic [7:0]  fifo_wr_data,
    output logic        fifo_reset,
    input  logic        fifo_full,
    output logic        mem_access,
    input  logic        mem_ack,
    output logic [18:0] mem_address,
    input  logic [15:0] mem_data
);

    typedef enum logic {
        ST_FETCH,
        ST_PUSH
    } state_t;

    state_t           state;
    logic [15:0]      fetch_ip;
    logic [1:0]       stage_cnt;
    logic [1:0][7:0]  stage_q;     // [0] is always the next byte to push
    logic             abort;       // outstanding access must be discarded
    logic             stall_gate;
    logic             fetch_go;
    logic [18:0]      fetch_word;

`ifdef PREFETCH_STALL_EN
    assign stall_gate = stall;
`else
    assign stall_gate = 1'b0;
`endif

    // Word address of CS:IP. cs*16 is even, so (cs*16 + ip) >> 1 equals
    // cs*8 + ip>>1, modulo 2^19 (the 20-bit physical wrap).
    assign fetch_word = {cs, 3'b000} + {4'b0000, fetch_ip[15:1]};

    // A new access may start only with FIFO room, no stall and no redirect
    // (a redirect changes fetch_ip at this edge, so the address is stale).
    assign fetch_go = ~fifo_full & ~stall_gate & ~load_new_ip;

    // Flush and push strobes are combinational so a redirect blocks the push
    // in the very cycle it arrives.
    assign fifo_reset   = load_new_ip & ~reset;
    assign fifo_wr_en   = (state == ST_PUSH) & ~fifo_full & ~load_new_ip & ~reset;
    assign fifo_wr_data = stage_q[0];

    // Fetch/push FSM with registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_ip    <= RESET_IP;
            stage_cnt   <= 2'd0;
            stage_q     <= '0;
            abort       <= 1'b0;
            mem_access  <= 1'b0;
            mem_address <= 19'd0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_access) begin
                        if (mem_ack) begin
                            mem_access <= 1'b0;
                            abort      <= 1'b0;
                            if (load_new_ip) begin
                                fetch_ip <= new_ip;
                            end else if (!abort) begin
                                if (fetch_ip[0]) begin
                                    // Odd IP: only the high byte belongs to the stream.
                                    stage_q   <= {8'h00, mem_data[15:8]};
                                    stage_cnt <= 2'd1;
                                    fetch_ip  <= fetch_ip + 16'd1;
                                end else begin
                                    stage_q   <= {mem_data[15:8], mem_data[7:0]};
                                    stage_cnt <= 2'd2;
                                    fetch_ip  <= fetch_ip + 16'd2;
                                end
                                state <= ST_PUSH;
                            end
                        end else if (load_new_ip) begin
                            // Bus request cannot be withdrawn; let it finish and drop it.
                            abort    <= 1'b1;
                            fetch_ip <= new_ip;
                        end
                    end else if (load_new_ip) begin
                        fetch_ip <= new_ip;
                    end else if (fetch_go) begin
                        mem_access  <= 1'b1;
                        mem_address <= fetch_word;
                    end
                end
                ST_PUSH: begin
                    if (load_new_ip) begin
                        stage_cnt <= 2'd0;
                        fetch_ip  <= new_ip;
                        state     <= ST_FETCH;
                    end else if (!fifo_full) begin
                        stage_q   <= {8'h00, stage_q[1]};
                        stage_cnt <= stage_cnt - 2'd1;
                        if (stage_cnt == 2'd1) begin
                            state <= ST_FETCH;
                            // Re-issue right after the last push to keep the stream dense.
                            if (fetch_go) begin
                                mem_access  <= 1'b1;
                                mem_address <= fetch_word;
                            end
                        end
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_prefetch_unit.sv
// tb_prefetch_unit: directed scenarios plus a randomized run checked
// against a byte-stream model (bytes at consecutive CS:IP from each
// redirect target) and a simple bus responder.
module tb_prefetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cs;
    logic [15:0] new_ip;
    logic        load_new_ip;
`ifdef PREFETCH_STALL_EN
    logic        stall;
`endif
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_reset;
    logic        fifo_full;
    logic        mem_access;
    logic        mem_ack;
    logic [18:0] mem_address;
    logic [15:0] mem_data;

    int n_cmp = 0;
    int n_bad = 0;

    prefetch_unit #(.RESET_IP(16'h0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs           (cs),
        .new_ip       (new_ip),
        .load_new_ip  (load_new_ip),
`ifdef PREFETCH_STALL_EN
        .stall        (stall),
`endif
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_reset   (fifo_reset),
        .fifo_full    (fifo_full),
        .mem_access   (mem_access),
        .mem_ack      (mem_ack),
        .mem_address  (mem_address),
        .mem_data     (mem_data)
    );

    always #5 clk = ~clk;

    // Memory contents as a function of word address.
    function automatic logic [15:0] memf(input logic [18:0] a);
        logic [31:0] t;
        t = ({13'd0, a} * 32'h9E37) ^ ({13'd0, a} >> 3);
        return t[15:0] ^ t[31:16];
    endfunction

    // Expected stream byte at CS:IP, using the 20-bit physical address.
    function automatic logic [7:0] exp_byte(input logic [15:0] c, input logic [15:0] ip);
        logic [19:0] p;
        logic [15:0] w;
        p = {c, 4'b0000} + {4'b0000, ip};
        w = memf(p[19:1]);
        return p[0] ? w[15:8] : w[7:0];
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; fifo_full = 1'b1; load_new_ip = 1'b0; mem_ack = 1'b0;
        new_ip = 16'h0; mem_data = 16'h0;
`ifdef PREFETCH_STALL_EN
        stall = 1'b0;
`endif
        step; step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        cs = 16'h1234;
        do_reset;
        #2;
        n_cmp++; if (mem_access !== 1'b0) begin n_bad++; $display("FAIL reset_mem_access: got %b want 0", mem_access); end
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", fifo_wr_en); end
        n_cmp++; if (fifo_reset !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_reset: got %b want 0", fifo_reset); end
        n_cmp++; if (mem_address !== 19'd0) begin n_bad++; $display("FAIL reset_mem_address: got %h want 0", mem_address); end
    endtask

    task automatic test_even_fetch;
        cs = 16'h0000;
        do_reset;
        new_ip = 16'h0100; load_new_ip = 1'b1; fifo_full = 1'b0;
        #2;
        n_cmp++; if (fifo_reset !== 1'b1) begin n_bad++; $display("FAIL even_fifo_reset: got %b want 1", fifo_reset); end
        step; load_new_ip = 1'b0;
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00080) begin n_bad++; $display("FAIL even_addr: got acc=%b addr=%h want acc=1 addr=00080", mem_access, mem_address); end
        mem_ack = 1'b1; mem_data = 16'h3412;
        step; mem_ack = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h12) begin n_bad++; $display("FAIL even_byte0: got en=%b d=%h want en=1 d=12", fifo_wr_en, fifo_wr_data); end
        step; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h34) begin n_bad++; $display("FAIL even_byte1: got en=%b d=%h want en=1 d=34", fifo_wr_en, fifo_wr_data); end
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00081 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL even_next_fetch: got acc=%b addr=%h en=%b want acc=1 addr=00081 en=0", mem_access, mem_address, fifo_wr_en); end
    endtask

    task automatic test_odd_fetch;
        cs = 16'h1000;
        do_reset;
        new_ip = 16'h0003; load_new_ip = 1'b1; fifo_full = 1'b0;
        step; load_new_ip = 1'b0;
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h08001) begin n_bad++; $display("FAIL odd_addr: got acc=%b addr=%h want acc=1 addr=08001", mem_access, mem_address); end
        mem_ack = 1'b1; mem_data = 16'hBBAA;
        step; mem_ack = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'hBB) begin n_bad++; $display("FAIL odd_byte: got en=%b d=%h want en=1 d=bb", fifo_wr_en, fifo_wr_data); end
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h08002 || fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL odd_next_fetch: got acc=%b addr=%h en=%b want acc=1 addr=08002 en=0", mem_access, mem_address, fifo_wr_en); end
    endtask

    task automatic test_backpressure;
        cs = 16'h0000;
        do_reset;
        new_ip = 16'h0100; load_new_ip = 1'b1; fifo_full = 1'b0;
        step; load_new_ip = 1'b0;
        step;
        mem_ack = 1'b1; mem_data = 16'h3412;
        step; mem_ack = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h12) begin n_bad++; $display("FAIL bp_byte0: got en=%b d=%h want en=1 d=12", fifo_wr_en, fifo_wr_data); end
        step; fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_cmp++; if (fifo_wr_en !== 1'b0 || mem_access !== 1'b0) begin n_bad++; $display("FAIL bp_hold: cycle %0d got en=%b acc=%b want 0 0", i, fifo_wr_en, mem_access); end
            step;
        end
        fifo_full = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h34) begin n_bad++; $display("FAIL bp_byte1: got en=%b d=%h want en=1 d=34", fifo_wr_en, fifo_wr_data); end
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00081) begin n_bad++; $display("FAIL bp_resume: got acc=%b addr=%h want acc=1 addr=00081", mem_access, mem_address); end
    endtask

    task automatic test_redirect_mid_access;
        bit found;
        cs = 16'h0000;
        do_reset;
        new_ip = 16'h0100; load_new_ip = 1'b1; fifo_full = 1'b0;
        step; load_new_ip = 1'b0;
        step;
        new_ip = 16'h0200; load_new_ip = 1'b1; #2;
        n_cmp++; if (fifo_reset !== 1'b1 || mem_access !== 1'b1) begin n_bad++; $display("FAIL redir_pulse: got rst=%b acc=%b want 1 1", fifo_reset, mem_access); end
        step; load_new_ip = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #2;
            n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00080) begin n_bad++; $display("FAIL redir_hold: got acc=%b addr=%h want acc=1 addr=00080", mem_access, mem_address); end
            step;
        end
        mem_ack = 1'b1; mem_data = 16'hDEAD;
        step; mem_ack = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 5 && !found; i++) begin
            #2;
            n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL redir_discard: got en=%b d=%h want en=0", fifo_wr_en, fifo_wr_data); end
            if (mem_access) found = 1'b1;
            else step;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL redir_refetch: got no access within 5 cycles want access"); end
        else if (mem_address !== 19'h00100) begin n_bad++; $display("FAIL redir_refetch: got addr=%h want 00100", mem_address); end
        step;
        mem_ack = 1'b1; mem_data = 16'h5678;
        step; mem_ack = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h78) begin n_bad++; $display("FAIL redir_new_byte: got en=%b d=%h want en=1 d=78", fifo_wr_en, fifo_wr_data); end
    endtask

    task automatic test_wrap;
        cs = 16'hFFFF;
        do_reset;
        new_ip = 16'hFFFE; load_new_ip = 1'b1; fifo_full = 1'b0;
        step; load_new_ip = 1'b0;
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h07FF7) begin n_bad++; $display("FAIL wrap_addr: got acc=%b addr=%h want acc=1 addr=07ff7", mem_access, mem_address); end
        mem_ack = 1'b1; mem_data = 16'h1111;
        step; mem_ack = 1'b0;
        step; step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h7FFF8) begin n_bad++; $display("FAIL wrap_next: got acc=%b addr=%h want acc=1 addr=7fff8", mem_access, mem_address); end
    endtask

`ifdef PREFETCH_STALL_EN
    task automatic test_stall;
        cs = 16'h0000;
        do_reset;
        stall = 1'b1;
        new_ip = 16'h0100; load_new_ip = 1'b1; fifo_full = 1'b0;
        step; load_new_ip = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            n_cmp++; if (mem_access !== 1'b0) begin n_bad++; $display("FAIL stall_idle: got acc=%b want 0", mem_access); end
            step;
        end
        stall = 1'b0;
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00080) begin n_bad++; $display("FAIL stall_start: got acc=%b addr=%h want acc=1 addr=00080", mem_access, mem_address); end
        stall = 1'b1; mem_ack = 1'b1; mem_data = 16'h3412;
        step; mem_ack = 1'b0; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h12) begin n_bad++; $display("FAIL stall_byte0: got en=%b d=%h want en=1 d=12", fifo_wr_en, fifo_wr_data); end
        step; #2;
        n_cmp++; if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'h34) begin n_bad++; $display("FAIL stall_byte1: got en=%b d=%h want en=1 d=34", fifo_wr_en, fifo_wr_data); end
        step;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (mem_access !== 1'b0) begin n_bad++; $display("FAIL stall_hold: got acc=%b want 0", mem_access); end
            step;
        end
        stall = 1'b0;
        step; #2;
        n_cmp++; if (mem_access !== 1'b1 || mem_address !== 19'h00081) begin n_bad++; $display("FAIL stall_resume: got acc=%b addr=%h want acc=1 addr=00081", mem_access, mem_address); end
    endtask
`endif

    // Random traffic: every pushed byte must be the next byte of memory at
    // CS:IP, counting from reset IP or the latest redirect target.
    task automatic test_random;
        logic [15:0] exp_ip;
        logic [18:0] pend_addr;
        bit          pend, prev_acc, prev_full, prev_stall;
        int          cnt, pushes;
        cs = 16'($urandom);
        do_reset;
        exp_ip = 16'h0000; pend = 1'b0; cnt = 0; pushes = 0; pend_addr = '0;
        prev_acc = 1'b0; prev_full = 1'b1; prev_stall = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fifo_full   = ($urandom_range(0, 3) == 0);
            load_new_ip = ($urandom_range(0, 39) == 0);
            new_ip      = 16'($urandom);
`ifdef PREFETCH_STALL_EN
            stall       = ($urandom_range(0, 4) == 0);
`endif
            mem_data = 16'($urandom);
            mem_ack  = 1'b0;
            if (mem_access) begin
                if (!pend) begin
                    pend = 1'b1; pend_addr = mem_address; cnt = $urandom_range(0, 3);
                    n_cmp++; if (prev_acc || prev_full || prev_stall) begin n_bad++; $display("FAIL rnd_issue_gate: got issue after acc=%b full=%b stall=%b want all 0", prev_acc, prev_full, prev_stall); end
                end else begin
                    n_cmp++; if (mem_address !== pend_addr) begin n_bad++; $display("FAIL rnd_addr_stable: got %h want %h", mem_address, pend_addr); end
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1; mem_data = memf(mem_address); pend = 1'b0;
                end else cnt--;
            end else if (pend) begin
                n_cmp++; n_bad++; $display("FAIL rnd_access_dropped: got acc=0 want 1 (addr %h)", pend_addr);
                pend = 1'b0;
            end
            #2;
            n_cmp++; if (fifo_reset !== load_new_ip) begin n_bad++; $display("FAIL rnd_fifo_reset: got %b want %b", fifo_reset, load_new_ip); end
            if (fifo_wr_en) begin
                n_cmp++;
                if (fifo_full || load_new_ip) begin n_bad++; $display("FAIL rnd_push_blocked: got push with full=%b load=%b want none", fifo_full, load_new_ip); end
                else if (fifo_wr_data !== exp_byte(cs, exp_ip)) begin n_bad++; $display("FAIL rnd_byte: ip %h got %h want %h", exp_ip, fifo_wr_data, exp_byte(cs, exp_ip)); end
                exp_ip = exp_ip + 16'd1;
                pushes++;
            end
            if (load_new_ip) exp_ip = new_ip;
            prev_acc  = mem_access && !mem_ack;
            prev_full = fifo_full;
`ifdef PREFETCH_STALL_EN
            prev_stall = stall;
`endif
            step;
        end
        mem_ack = 1'b0; load_new_ip = 1'b0;
        n_cmp++; if (pushes < 100) begin n_bad++; $display("FAIL rnd_progress: got %0d pushes want >= 100", pushes); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cs = 16'h0; new_ip = 16'h0; load_new_ip = 1'b0;
        fifo_full = 1'b1; mem_ack = 1'b0; mem_data = 16'h0;
`ifdef PREFETCH_STALL_EN
        stall = 1'b0;
`endif
        test_reset;
        test_even_fetch;
        test_odd_fetch;
        test_backpressure;
        test_redirect_mid_access;
        test_wrap;
`ifdef PREFETCH_STALL_EN
        test_stall;
`endif
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
